// File: rtl/i2s_sample_rx.sv
// I2S-style stereo deserialiser: oversamples bclk/lrclk/sdata and emits {left, right} words.
// Optional macro I2S_FRAME_ERR_EN adds a frame_err pulse output for short or orphaned frames.
module i2s_sample_rx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  clear,
    input  logic                  bclk_in,
    input  logic                  lrclk_in,
    input  logic                  sdata_in,
    output logic [2*DATA_W-1:0]   sample_out,
    output logic                  sample_ready
`ifdef I2S_FRAME_ERR_EN
    ,
    output logic                  frame_err
`endif
);

    // state      | meaning
    // IDLE       | no frame alignment yet, waiting for a left boundary
    // LEFT       | shifting left channel bits
    // LEFT_DONE  | left word complete, waiting for the right boundary
    // RIGHT      | shifting right channel bits
    // RIGHT_DONE | stereo word emitted, waiting for the next left boundary
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEFT       = 3'd1,
        LEFT_DONE  = 3'd2,
        RIGHT      = 3'd3,
        RIGHT_DONE = 3'd4
    } state_t;

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   bclk_prev;
    logic                   bit_edge;
    logic                   lr_q;
    logic                   sd_q;
    logic                   lr_last;
    logic [DATA_W-1:0]      left_sr;
    logic [DATA_W-1:0]      right_sr;
    logic                   boundary;

    // bit_edge, lr_q and sd_q are registered together so they stay aligned
    always_comb begin
        boundary = bit_edge && (lr_q != lr_last);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bclk_sync    <= '0;
            lr_sync      <= '0;
            sd_sync      <= '0;
            bclk_prev    <= 1'b0;
            bit_edge     <= 1'b0;
            lr_q         <= 1'b0;
            sd_q         <= 1'b0;
            lr_last      <= 1'b0;
            left_sr      <= '0;
            right_sr     <= '0;
            sample_out   <= '0;
            sample_ready <= 1'b0;
`ifdef I2S_FRAME_ERR_EN
            frame_err    <= 1'b0;
`endif
        end else if (clear) begin
            state        <= IDLE;
            cnt          <= '0;
            bclk_sync    <= '0;
            lr_sync      <= '0;
            sd_sync      <= '0;
            bclk_prev    <= 1'b0;
            bit_edge     <= 1'b0;
            lr_q         <= 1'b0;
            sd_q         <= 1'b0;
            lr_last      <= 1'b0;
            left_sr      <= '0;
            right_sr     <= '0;
            sample_out   <= '0;
            sample_ready <= 1'b0;
`ifdef I2S_FRAME_ERR_EN
            frame_err    <= 1'b0;
`endif
        end else begin
            bclk_sync    <= {bclk_sync[SYNC_STAGES-2:0], bclk_in};
            lr_sync      <= {lr_sync[SYNC_STAGES-2:0], lrclk_in};
            sd_sync      <= {sd_sync[SYNC_STAGES-2:0], sdata_in};
            bclk_prev    <= bclk_sync[SYNC_STAGES-1];
            bit_edge     <= bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
            lr_q         <= lr_sync[SYNC_STAGES-1];
            sd_q         <= sd_sync[SYNC_STAGES-1];
            sample_ready <= 1'b0;
`ifdef I2S_FRAME_ERR_EN
            frame_err    <= 1'b0;
`endif
            if (bit_edge) begin
                lr_last <= lr_q;
            end

            case (state)
                IDLE: begin
                    if (boundary) begin
                        if (!lr_q) begin
                            state <= LEFT;
                            cnt   <= '0;
                        end else begin
`ifdef I2S_FRAME_ERR_EN
                            frame_err <= 1'b1;
`endif
                        end
                    end
                end
                LEFT: begin
                    if (boundary) begin
                        // short left slot: drop the partial word
`ifdef I2S_FRAME_ERR_EN
                        frame_err <= 1'b1;
`endif
                        cnt <= '0;
                        if (lr_q) begin
                            state <= IDLE;
                        end
                    end else if (bit_edge) begin
                        left_sr <= {left_sr[DATA_W-2:0], sd_q};
                        if (cnt == CNT_LAST) begin
                            state <= LEFT_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                LEFT_DONE: begin
                    if (boundary) begin
                        cnt   <= '0;
                        state <= lr_q ? RIGHT : LEFT;
                    end
                end
                RIGHT: begin
                    if (boundary) begin
`ifdef I2S_FRAME_ERR_EN
                        frame_err <= 1'b1;
`endif
                        cnt   <= '0;
                        state <= lr_q ? IDLE : LEFT;
                    end else if (bit_edge) begin
                        right_sr <= {right_sr[DATA_W-2:0], sd_q};
                        if (cnt == CNT_LAST) begin
                            sample_out   <= {left_sr, right_sr[DATA_W-2:0], sd_q};
                            sample_ready <= 1'b1;
                            state        <= RIGHT_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                RIGHT_DONE: begin
                    if (boundary) begin
                        cnt <= '0;
                        if (!lr_q) begin
                            state <= LEFT;
                        end else begin
                            state <= IDLE;
`ifdef I2S_FRAME_ERR_EN
                            frame_err <= 1'b1;
`endif
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_sample_rx.sv
// Directed bench for i2s_sample_rx: bclk at 8x slower than clk, hand-computed expected words.
module tb_i2s_sample_rx;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        clear;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic [31:0] sample_out;
    logic        sample_ready;
`ifdef I2S_FRAME_ERR_EN
    logic        frame_err;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pulse_cnt = 0;
    int          unstable  = 0;
    int          err_cnt   = 0;
    int          p0;
    int          e0;
    logic [31:0] prev_out = '0;
    logic        allow_change = 1'b1;
    logic [15:0] rword;

    i2s_sample_rx #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .clear        (clear),
        .bclk_in      (bclk),
        .lrclk_in     (lrclk),
        .sdata_in     (sdata),
        .sample_out   (sample_out),
        .sample_ready (sample_ready)
`ifdef I2S_FRAME_ERR_EN
        ,
        .frame_err    (frame_err)
`endif
    );

    always #5 clk = ~clk;

    // output watcher: counts pulses and flags any change of sample_out without a pulse
    always @(negedge clk) begin
        if (sample_ready === 1'b1) begin
            pulse_cnt++;
        end else if (!allow_change && sample_out !== prev_out) begin
            unstable++;
        end
        prev_out = sample_out;
`ifdef I2S_FRAME_ERR_EN
        if (frame_err === 1'b1) err_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic lr, input logic sd);
        @(negedge clk);
        bclk  = 1'b0;
        lrclk = lr;
        sdata = sd;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // one channel slot: boundary bit, nbits of data MSB first, then 1s up to total
    task automatic send_slot(input logic lr, input logic [15:0] d, input int nbits, input int total);
        send_bit(lr, 1'b1);
        for (int i = 0; i < total; i++) begin
            send_bit(lr, (i < nbits) ? d[15-i] : 1'b1);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l, 16, 16);
        send_slot(1'b1, r, 16, 16);
        repeat (6) @(negedge clk);
    endtask

    // full frame except that the 16th right bit's rising edge is left to the caller's timing
    task automatic frame_until_last(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l, 16, 16);
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) begin
            send_bit(1'b1, r[15-i]);
        end
        @(negedge clk);
        bclk  = 1'b0;
        sdata = r[0];
        repeat (4) @(negedge clk);
        bclk = 1'b1;
    endtask

    initial begin
        n_reset = 1'b0;
        clear   = 1'b0;
        bclk    = 1'b0;
        lrclk   = 1'b1;
        sdata   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", sample_out, 32'h0);
        check("reset_ready", {31'b0, sample_ready}, 32'h0);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        allow_change = 1'b0;
        send_bit(1'b1, 1'b0);

        // nominal frame with pulse latency measured from the last right bclk rise
        p0 = pulse_cnt;
        rword = 16'h0F01;
        frame_until_last(16'hA5C3, rword);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("latency_k%0d", k), {31'b0, sample_ready}, (k == 4) ? 32'h1 : 32'h0);
        end
        repeat (4) @(negedge clk);
        check("nominal_word", sample_out, 32'hA5C3_0F01);
        check("nominal_pulses", 32'(pulse_cnt - p0), 32'd1);

        // back-to-back frames
        p0 = pulse_cnt;
        send_frame(16'h8000, 16'h7FFF);
        check("b2b_word1", sample_out, 32'h8000_7FFF);
        check("b2b_pulses1", 32'(pulse_cnt - p0), 32'd1);
        send_frame(16'hFFFF, 16'h0000);
        check("b2b_word2", sample_out, 32'hFFFF_0000);
        check("b2b_pulses2", 32'(pulse_cnt - p0), 32'd2);

        // 24-bit slots, only the first 16 bits count
        p0 = pulse_cnt;
        send_slot(1'b0, 16'h1234, 16, 24);
        send_slot(1'b1, 16'h5678, 16, 24);
        repeat (6) @(negedge clk);
        check("long_word", sample_out, 32'h1234_5678);
        check("long_pulses", 32'(pulse_cnt - p0), 32'd1);

        // short left slot is discarded, next full frame recovers
        p0 = pulse_cnt;
        e0 = err_cnt;
        send_slot(1'b0, 16'hFFFF, 10, 10);
        send_slot(1'b1, 16'h0000, 16, 16);
        repeat (6) @(negedge clk);
        check("short_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        check("short_held", sample_out, 32'h1234_5678);
`ifdef I2S_FRAME_ERR_EN
        check("short_frame_err", 32'(err_cnt - e0), 32'd1);
`endif
        send_frame(16'h00FF, 16'hFF00);
        check("recover_word", sample_out, 32'h00FF_FF00);
        check("recover_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("stable_between_pulses", 32'(unstable), 32'd0);

        // clear coincident with the completing bit edge wins
        p0 = pulse_cnt;
        frame_until_last(16'h4242, 16'h2424);
        repeat (3) @(posedge clk);
        @(negedge clk);
        allow_change = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("clearwin_ready", {31'b0, sample_ready}, 32'h0);
        check("clearwin_out", sample_out, 32'h0);
        @(negedge clk);
        clear = 1'b0;
        repeat (6) @(negedge clk);
        check("clearwin_pulses", 32'(pulse_cnt - p0), 32'd0);
        allow_change = 1'b0;

        // async reset during the right slot
        send_frame(16'hDEAD, 16'hBEEF);
        check("pre_reset_word", sample_out, 32'hDEAD_BEEF);
        p0 = pulse_cnt;
        send_slot(1'b0, 16'h1111, 16, 16);
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1);
        @(negedge clk);
        allow_change = 1'b1;
        n_reset = 1'b0;
        #1;
        check("reset_mid_out", sample_out, 32'h0);
        @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
        repeat (6) @(negedge clk);
        check("reset_mid_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("reset_mid_after", sample_out, 32'h0);
        allow_change = 1'b0;

        // synchronous clear during the right slot
        send_frame(16'hDEAD, 16'hBEEF);
        check("pre_clear_word", sample_out, 32'hDEAD_BEEF);
        p0 = pulse_cnt;
        send_slot(1'b0, 16'h2222, 16, 16);
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1);
        @(negedge clk);
        allow_change = 1'b1;
        clear = 1'b1;
        #1;
        check("clear_before_edge", sample_out, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        check("clear_after_edge", sample_out, 32'h0);
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
        repeat (6) @(negedge clk);
        check("clear_mid_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("clear_mid_after", sample_out, 32'h0);

        // stream starting in the right slot
        @(negedge clk);
        n_reset = 1'b0;
        bclk    = 1'b0;
        lrclk   = 1'b1;
        @(negedge clk);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        allow_change = 1'b0;
        p0 = pulse_cnt;
        send_slot(1'b1, 16'hABCD, 16, 16);
        repeat (6) @(negedge clk);
        check("startup_right_ignored", 32'(pulse_cnt - p0), 32'd0);
        check("startup_out_zero", sample_out, 32'h0);
        send_frame(16'h1357, 16'h2468);
        check("startup_first_word", sample_out, 32'h1357_2468);
        check("startup_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("stable_final", 32'(unstable), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_sample_rx.md
Name: i2s_sample_rx

Overview:
- Upstream stage of the fader. Deserialises an external I2S-style stereo bit stream into 32-bit stereo words: left in [31:16], right in [15:0].
- Output word drives the fader's `signal_in`. A one-cycle `sample_ready` strobe marks each new word.
- Single `clk` domain. External `bclk`/`lrclk`/`sdata` are oversampled through synchronisers.

Parameters:
- DATA_W, 16, bits per channel. The output word is 2*DATA_W.
- SYNC_STAGES, 2, flip-flop stages per synchroniser on each external input. Minimum 2.

Ports:
- clk  in  1  system clock. Must be at least 4x the bclk frequency.
- n_reset  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear. Same effect as reset, but on the clk edge.
- bclk_in  in  1  external bit clock (asynchronous).
- lrclk_in  in  1  external word select: 0 = left, 1 = right (asynchronous).
- sdata_in  in  1  external serial data, MSB first (asynchronous).
- sample_out  out  2*DATA_W  last complete stereo word {left, right}.
- sample_ready  out  1  one-cycle pulse when sample_out updates.

Behaviour:
- Reset (n_reset=0, async) and clear (sync) set:
  - sample_out=0, sample_ready=0;
  - FSM=IDLE, bit counter=0;
  - shift registers=0, synchronisers=0.
- Synchroniser and bit-edge detection:
  - Each input passes through SYNC_STAGES flops. A previous-value flop holds the last synchronised bclk.
  - A "bit edge" is the clk cycle where synchronised bclk=1 and the previous value=0.
  - lrclk and sdata are sampled only on bit edges, from their synchronised values.
  - Latency from pin to bit edge is SYNC_STAGES+1 clk cycles.
- Word boundary:
  - A boundary is a bit edge where sampled lrclk differs from the lrclk sampled at the previous bit edge.
  - The sdata bit at the boundary edge is ignored (I2S one-bit delay).
  - The following DATA_W bit edges shift sdata in, MSB first.
  - Bits after the DATA_W-th, up to the next boundary, are ignored.
- FSM states:
  - IDLE: wait for a boundary with new lrclk=0 -> LEFT, counter=0.
  - LEFT: shift one bit per bit edge into left_sr, counter++. On reaching DATA_W -> LEFT_DONE.
  - LEFT_DONE: wait for a boundary with lrclk=1 -> RIGHT, counter=0.
  - RIGHT: shift into right_sr. On the DATA_W-th bit, load sample_out={left_sr, right_sr incl. this bit} on the next clk edge and pulse sample_ready for exactly that cycle; then -> RIGHT_DONE.
  - RIGHT_DONE: wait for a boundary with lrclk=0 -> LEFT, counter=0.
- Short frame: a boundary arrives in LEFT or RIGHT before DATA_W bits have been collected.
  - The partial word is discarded; sample_out is held and no ready pulse is issued.
  - If the new lrclk=0 -> LEFT (restart). Otherwise -> IDLE.
- sample_out changes only together with a sample_ready pulse. Between pulses it is stable.
- clear asserted in the same cycle as a completing bit edge: clear wins. No pulse; sample_out=0.
- Asynchronous reset mid-word: the output is zeroed immediately. The first valid word is the first complete L+R pair after a left boundary.

Optional Feature:
- I2S_FRAME_ERR_EN:
  - Defined: adds output `frame_err` (1 bit, reset 0). It pulses for one cycle on every short-frame discard, and on a boundary into lrclk=1 seen in IDLE or LEFT_DONE when no left word was pending.
  - Undefined: the port is absent. Discard and recovery behaviour is identical and silent.

Test Plan:
- Nominal frame, clk=8x bclk:
  - Stimulus: left=16'hA5C3, right=16'h0F01, standard I2S framing.
  - Required: sample_out=32'hA5C3_0F01; a single sample_ready pulse SYNC_STAGES+2 clk cycles after the 16th right bclk rising edge.
- Back-to-back frames:
  - Stimulus: {16'h8000,16'h7FFF} then {16'hFFFF,16'h0000}.
  - Required: exactly two pulses with those values; sample_out stable between pulses.
- Long slots:
  - Stimulus: 24 bclk per channel; first 16 bits 16'h1234 / 16'h5678, then 8 junk bits of 1s.
  - Required: sample_out=32'h1234_5678.
- Short left slot:
  - Stimulus: 10 bits, then lrclk toggles to 1, then a full frame {16'h00FF,16'hFF00}.
  - Required: no pulse for the short frame (frame_err=1 pulse when the macro is defined); the next full frame gives 32'h00FF_FF00.
- Reset and clear mid-word:
  - Stimulus: n_reset low for 1 clk during the right slot after a valid word 32'hDEAD_BEEF.
  - Required: sample_out=0 immediately and no pulse for the interrupted frame.
  - Repeat with clear: same result, but sample_out zeroes on the next clk edge.
- Startup in right slot:
  - Stimulus: stream begins with lrclk=1.
  - Required: the right data is ignored; the first pulse follows the first complete left+right pair.
